// File: rtl/sbox_seq_ctrl.sv
// Time-multiplexes one shared DES S-box lookup across S1..S8 for a 48-bit operand.
// Define SBOX_SEQ_PIPE_EN to register sbox_out before capture (adds one RUN cycle).
module sbox_seq_ctrl #(
    parameter int NUM_BOX = 8,
    parameter int ID_BASE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic [5:0]  sbox_in,
    output logic [3:0]  sbox_id,
    input  logic [3:0]  sbox_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(NUM_BOX - 1);

    state_t          state_q, state_d;
    logic [7:0][5:0] operand_q, operand_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0][3:0] out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;
    logic            issue;

`ifdef SBOX_SEQ_PIPE_EN
    logic [3:0]      pipe_nib_q, pipe_nib_d;
    logic [2:0]      pipe_idx_q, pipe_idx_d;
    logic            pipe_vld_q, pipe_vld_d;
    logic            issued_all_q, issued_all_d;
`endif

    // Chunk/nibble index 0 maps to the most significant slice (S1).
    always_comb begin
`ifdef SBOX_SEQ_PIPE_EN
        issue = (state_q == RUN) && !issued_all_q;
`else
        issue = (state_q == RUN);
`endif
        sbox_in = 6'd0;
        sbox_id = 4'd0;
        if (issue) begin
            sbox_in = operand_q[3'd7 - idx_q];
            sbox_id = {1'b0, idx_q} + 4'(ID_BASE);
        end
    end

    always_comb begin
        state_d     = state_q;
        operand_d   = operand_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
`ifdef SBOX_SEQ_PIPE_EN
        pipe_nib_d   = pipe_nib_q;
        pipe_idx_d   = pipe_idx_q;
        pipe_vld_d   = 1'b0;
        issued_all_d = issued_all_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    operand_d  = in_data;
                    idx_d      = 3'd0;
                    out_data_d = '0;
                    state_d    = RUN;
`ifdef SBOX_SEQ_PIPE_EN
                    issued_all_d = 1'b0;
`endif
                end
            end
            RUN: begin
`ifdef SBOX_SEQ_PIPE_EN
                if (issue) begin
                    pipe_nib_d = sbox_out;
                    pipe_idx_d = idx_q;
                    pipe_vld_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        issued_all_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                // Capture lags issue by one cycle; the last capture ends RUN.
                if (pipe_vld_q) begin
                    out_data_d[3'd7 - pipe_idx_q] = pipe_nib_q;
                    if (pipe_idx_q == LAST_IDX) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end
                end
`else
                out_data_d[3'd7 - idx_q] = sbox_out;
                if (idx_q == LAST_IDX) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // Abort wins over every transition, including a same-cycle accept.
        if (flush) begin
            state_d     = IDLE;
            operand_d   = '0;
            idx_d       = 3'd0;
            out_data_d  = '0;
            out_valid_d = 1'b0;
`ifdef SBOX_SEQ_PIPE_EN
            pipe_nib_d   = 4'd0;
            pipe_idx_d   = 3'd0;
            pipe_vld_d   = 1'b0;
            issued_all_d = 1'b0;
`endif
        end

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            operand_q   <= '0;
            idx_q       <= 3'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SBOX_SEQ_PIPE_EN
            pipe_nib_q   <= 4'd0;
            pipe_idx_q   <= 3'd0;
            pipe_vld_q   <= 1'b0;
            issued_all_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            operand_q   <= operand_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
`ifdef SBOX_SEQ_PIPE_EN
            pipe_nib_q   <= pipe_nib_d;
            pipe_idx_q   <= pipe_idx_d;
            pipe_vld_q   <= pipe_vld_d;
            issued_all_q <= issued_all_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sbox_seq_ctrl.sv
// Directed bench for sbox_seq_ctrl; the bench models the shared DES S-box ROM itself.
module tb_sbox_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic [5:0]  sbox_in;
    logic [3:0]  sbox_id;
    logic [3:0]  sbox_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int n_vec  = 0;
    int n_fail = 0;

`ifdef SBOX_SEQ_PIPE_EN
    localparam int          LAT     = 9;
    localparam logic [63:0] EXP_IDS = 64'h123456780;
`else
    localparam int          LAT     = 8;
    localparam logic [63:0] EXP_IDS = 64'h12345678;
`endif

    typedef struct {
        logic [47:0] din;
        logic [31:0] dout;
        int          hold;
    } vec_t;

    vec_t vt[5];

    sbox_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sbox_in   (sbox_in),
        .sbox_id   (sbox_id),
        .sbox_out  (sbox_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Standard DES tables, row-major (row = {b5,b0}, column = b4..b1), one hex digit per entry.
    function automatic logic [3:0] des_sbox(input logic [3:0] id, input logic [5:0] x);
        string s;
        int    pos;
        int    ci;
        case (id)
            4'd1: s = "E4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D";
            4'd2: s = "F18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9";
            4'd3: s = "A09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C";
            4'd4: s = "7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E";
            4'd5: s = "2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453";
            4'd6: s = "C1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D";
            4'd7: s = "4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C";
            4'd8: s = "D2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B";
            default: s = "";
        endcase
        if (s.len() != 64) return 4'hF;
        pos = int'({x[5], x[0]}) * 16 + int'(x[4:1]);
        ci  = int'(s[pos]);
        return (ci >= 65) ? 4'(ci - 55) : 4'(ci - 48);
    endfunction

    // Garbage on id 0 so a capture outside RUN shows up in the result.
    always_comb begin
        sbox_out = 4'hF;
        if (sbox_id != 4'd0) sbox_out = des_sbox(sbox_id, sbox_in);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " in_ready before accept"}, 64'(in_ready), 64'(1));
    endtask

    task automatic run_op(input string tag, input logic [47:0] din,
                          input logic [31:0] dout, input int hold);
        int          lat;
        logic [63:0] idseq;
        wait_ready(tag);
        in_data  = din;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat   = 0;
        idseq = '0;
        while (out_valid !== 1'b1 && lat < 20) begin
            idseq = {idseq[59:0], sbox_id};
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(LAT));
        check({tag, " sbox_id sequence"}, idseq, EXP_IDS);
        check({tag, " out_data"}, 64'(out_data), 64'(dout));
        check({tag, " done in_ready/busy"}, 64'({in_ready, busy}), 64'(2'b01));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check({tag, " stall hold"}, 64'({out_valid, in_ready, busy, out_data}),
                  64'({1'b1, 1'b0, 1'b1, dout}));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " release"}, 64'({out_valid, in_ready, busy}), 64'(3'b010));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;

        vt[0] = '{48'h000000000000, 32'hEFA72C4D, 0};
        vt[1] = '{48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 0};
        vt[2] = '{48'h6117BA866527, 32'h5C82B597, 0};
        vt[3] = '{48'h041041041041, 32'h03DDEAD1, 2};
        vt[4] = '{48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 5};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        #12;
        check("reset in_ready", 64'(in_ready), 64'(0));
        check("reset out_valid/busy", 64'({out_valid, busy}), 64'(0));
        check("reset out_data", 64'(out_data), 64'(0));
        check("reset sbox_in/sbox_id", 64'({sbox_in, sbox_id}), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post-reset in_ready", 64'(in_ready), 64'(1));

        for (int i = 0; i < 5; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].din, vt[i].dout, vt[i].hold);
        end

        // Flush in the middle of RUN, at idx 4.
        wait_ready("flush");
        in_data  = 48'h6117BA866527;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (sbox_id !== 4'd5 && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        check("flush reach idx4", 64'(sbox_id), 64'(5));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush state", 64'({sbox_id, busy, in_ready, out_valid}),
              64'({4'd0, 1'b0, 1'b1, 1'b0}));
        check("flush out_data", 64'(out_data), 64'(0));
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("flush no out_valid", 64'(seen), 64'(0));
        run_op("post-flush", 48'h000000000000, 32'hEFA72C4D, 0);

        // Flush coincident with an accept drops the operand.
        in_data  = 48'hFFFFFFFFFFFF;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush+accept dropped", 64'({busy, sbox_id, in_ready}), 64'({1'b0, 4'd0, 1'b1}));
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        check("flush+accept stays idle", 64'(seen), 64'(0));

        // Asynchronous reset mid-RUN, between clock edges.
        wait_ready("async reset");
        in_data  = 48'h6117BA866527;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset outputs",
              64'({out_valid, in_ready, busy, sbox_id, sbox_in, out_data}), 64'(0));
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("after reset in_ready/busy", 64'({in_ready, busy}), 64'(2'b10));
        run_op("after reset a", 48'h6117BA866527, 32'h5C82B597, 0);
        run_op("after reset b", 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
